// File: rtl/stack_unit_ctrl.sv
// Operand stack for the multicycle stack-machine controller.
// Top-of-stack lives in a register; older entries spill into a synchronous-read
// array. A pop that must refill TOS from the array stalls for one REFILL cycle.
//
// Ports:
//   clk_i, rst_ni       clock and synchronous active-low reset
//   push_i, pop_i       push din_i / pop TOS to dout_o (only accepted while ready_o=1)
//   tos_rd_i            peek TOS to dout_o without changing state
//   din_i               push data
//   err_clr_i           clear sticky ovf_err_o / unf_err_o
//   ready_o             1 when commands are accepted (IDLE)
//   dout_o              registered pop/peek data
//   dout_valid_o        one-cycle pulse after an accepted pop/peek
//   count_o             entries held, 0..DEPTH
//   empty_o, full_o     occupancy flags
//   tos_zero_o          stack non-empty and TOS == 0 (forced low during REFILL)
//   ovf_err_o           sticky: push attempted while full
//   unf_err_o           sticky: pop/peek attempted while empty
module stack_unit_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             tos_rd_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             err_clr_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] dout_o,
    output logic             dout_valid_o,
    output logic [AW:0]      count_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             tos_zero_o,
    output logic             ovf_err_o,
    output logic             unf_err_o
);

    typedef enum logic [0:0] {StIdle, StRefill} state_e;

    localparam logic [AW:0]   CountOne  = (AW + 1)'(1);
    localparam logic [AW:0]   CountTwo  = (AW + 1)'(2);
    localparam logic [AW:0]   CountFull = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] SpOne     = AW'(1);

    state_e           state_q, state_d;
    logic [AW-1:0]    sp_q, sp_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] tos_q, tos_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dv_q, dv_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    // Spill array: holds everything below TOS, mem_q[sp_q-1] is the next entry down.
    logic [WIDTH-1:0] mem_q [DEPTH-1];
    logic [WIDTH-1:0] rd_data_q;
    logic             mem_we;
    logic             rd_en;
    logic             ovf_set;
    logic             unf_set;
    logic             empty;
    logic             full;

    assign empty = (count_q == '0);
    assign full  = (count_q == CountFull);

    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        count_d = count_q;
        tos_d   = tos_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;
        mem_we  = 1'b0;
        rd_en   = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (push_i && pop_i) begin
                    if (empty) begin
                        // Nothing to replace: behaves as a plain push onto an empty stack.
                        tos_d   = din_i;
                        count_d = CountOne;
                        unf_set = 1'b1;
                    end else begin
                        dout_d = tos_q;
                        dv_d   = 1'b1;
                        tos_d  = din_i;
                    end
                end else if (push_i) begin
                    if (full) begin
                        ovf_set = 1'b1;
                    end else begin
                        if (!empty) begin
                            mem_we = 1'b1;
                            sp_d   = sp_q + SpOne;
                        end
                        tos_d   = din_i;
                        count_d = count_q + CountOne;
                    end
                end else if (pop_i) begin
                    if (empty) begin
                        unf_set = 1'b1;
                    end else begin
                        dout_d  = tos_q;
                        dv_d    = 1'b1;
                        count_d = count_q - CountOne;
                        if (count_q >= CountTwo) begin
                            sp_d    = sp_q - SpOne;
                            rd_en   = 1'b1;
                            state_d = StRefill;
                        end
                    end
                end else if (tos_rd_i) begin
                    if (empty) begin
                        unf_set = 1'b1;
                    end else begin
                        dout_d = tos_q;
                        dv_d   = 1'b1;
                    end
                end
            end
            StRefill: begin
                tos_d   = rd_data_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A same-cycle set takes precedence over err_clr_i.
        ovf_d = ovf_set | (ovf_q & ~err_clr_i);
        unf_d = unf_set | (unf_q & ~err_clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            sp_q    <= '0;
            count_q <= '0;
            tos_q   <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            count_q <= count_d;
            tos_q   <= tos_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Array and its read register carry no reset; validity is tracked by sp_q/count_q.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[sp_q] <= tos_q;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[sp_q - SpOne];
        end
    end

    assign ready_o      = (state_q == StIdle);
    assign dout_o       = dout_q;
    assign dout_valid_o = dv_q;
    assign count_o      = count_q;
    assign empty_o      = empty;
    assign full_o       = full;
    assign tos_zero_o   = (state_q == StIdle) && !empty && (tos_q == '0);
    assign ovf_err_o    = ovf_q;
    assign unf_err_o    = unf_q;

endmodule

// File: tb/tb_stack_unit_ctrl.sv
// Directed bench for stack_unit_ctrl: a vector table for single-cycle commands plus
// hand-written sequences for fill/drain, overflow, and reset during REFILL.
module tb_stack_unit_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam bit T = 1'b1;
    localparam bit F = 1'b0;

    logic             clk;
    logic             rst_n;
    logic             push;
    logic             pop;
    logic             tos_rd;
    logic [WIDTH-1:0] din;
    logic             err_clr;
    logic             ready;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [AW:0]      count;
    logic             empty;
    logic             full;
    logic             tos_zero;
    logic             ovf_err;
    logic             unf_err;

    int checks   = 0;
    int failures = 0;

    stack_unit_ctrl #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .push_i      (push),
        .pop_i       (pop),
        .tos_rd_i    (tos_rd),
        .din_i       (din),
        .err_clr_i   (err_clr),
        .ready_o     (ready),
        .dout_o      (dout),
        .dout_valid_o(dout_valid),
        .count_o     (count),
        .empty_o     (empty),
        .full_o      (full),
        .tos_zero_o  (tos_zero),
        .ovf_err_o   (ovf_err),
        .unf_err_o   (unf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         push;
        bit         pop;
        bit         rd;
        bit         clr;
        logic [7:0] din;
        bit         e_ready;
        bit         e_dv;
        bit         chk_dout;
        logic [7:0] e_dout;
        int         e_count;
        bit         e_tz;
        bit         e_ovf;
        bit         e_unf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one command for one clock and sample just after the edge.
    task automatic step(input bit p, input bit po, input bit r, input bit c,
                        input logic [7:0] d);
        @(negedge clk);
        push    = p;
        pop     = po;
        tos_rd  = r;
        err_clr = c;
        din     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input bit p, input bit po, input bit r, input bit c,
                       input logic [7:0] d, input bit rdy, input bit dv, input bit cd,
                       input logic [7:0] dq, input int cnt, input bit tz, input bit ovf,
                       input bit unf);
        vec_t v;
        v.push = p; v.pop = po; v.rd = r; v.clr = c; v.din = d;
        v.e_ready = rdy; v.e_dv = dv; v.chk_dout = cd; v.e_dout = dq;
        v.e_count = cnt; v.e_tz = tz; v.e_ovf = ovf; v.e_unf = unf;
        vecs.push_back(v);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        tos_rd  = 1'b0;
        err_clr = 1'b0;
        din     = '0;
        repeat (cycles) @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        tos_rd  = 1'b0;
        err_clr = 1'b0;
        din     = '0;

        // push/pop/rd/clr/din | ready/dv/chk_dout/dout/count/tz/ovf/unf
        // LIFO order, REFILL stall only on pops that leave entries below TOS.
        add(T, F, F, F, 8'h11, T, F, F, 8'h00, 1, F, F, F);
        add(T, F, F, F, 8'h22, T, F, F, 8'h00, 2, F, F, F);
        add(T, F, F, F, 8'h33, T, F, F, 8'h00, 3, F, F, F);
        add(F, T, F, F, 8'h00, F, T, T, 8'h33, 2, F, F, F);
        add(F, F, F, F, 8'h00, T, F, F, 8'h00, 2, F, F, F);
        add(F, T, F, F, 8'h00, F, T, T, 8'h22, 1, F, F, F);
        add(F, F, F, F, 8'h00, T, F, F, 8'h00, 1, F, F, F);
        add(F, T, F, F, 8'h00, T, T, T, 8'h11, 0, F, F, F);
        add(F, F, F, F, 8'h00, T, F, F, 8'h00, 0, F, F, F);
        // Underflow handling on an empty stack.
        add(F, T, F, F, 8'h00, T, F, F, 8'h00, 0, F, F, T);
        add(F, F, F, T, 8'h00, T, F, F, 8'h00, 0, F, F, F);
        add(F, F, T, F, 8'h00, T, F, F, 8'h00, 0, F, F, T);
        add(F, F, F, T, 8'h00, T, F, F, 8'h00, 0, F, F, F);
        add(T, T, F, F, 8'h05, T, F, F, 8'h00, 1, F, F, T);
        add(F, F, F, T, 8'h00, T, F, F, 8'h00, 1, F, F, F);
        add(F, F, T, F, 8'h00, T, T, T, 8'h05, 1, F, F, F);
        // Build [0x07,0x00], replace TOS, then push ignored during REFILL.
        add(F, T, F, F, 8'h00, T, T, T, 8'h05, 0, F, F, F);
        add(T, F, F, F, 8'h07, T, F, F, 8'h00, 1, F, F, F);
        add(T, F, F, F, 8'h00, T, F, F, 8'h00, 2, T, F, F);
        add(T, T, F, F, 8'h09, T, T, T, 8'h00, 2, F, F, F);
        add(F, T, F, F, 8'h00, F, T, T, 8'h09, 1, F, F, F);
        add(T, F, F, F, 8'hAA, T, F, F, 8'h00, 1, F, F, F);
        add(F, F, T, F, 8'h00, T, T, T, 8'h07, 1, F, F, F);

        // Reset held two cycles.
        do_reset(2);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_dv", 32'(dout_valid), 32'd0);
        check("rst_tz", 32'(tos_zero), 32'd0);
        check("rst_ovf", 32'(ovf_err), 32'd0);
        check("rst_unf", 32'(unf_err), 32'd0);

        foreach (vecs[i]) begin
            step(vecs[i].push, vecs[i].pop, vecs[i].rd, vecs[i].clr, vecs[i].din);
            check($sformatf("v%0d_ready", i), 32'(ready), 32'(vecs[i].e_ready));
            check($sformatf("v%0d_dv", i), 32'(dout_valid), 32'(vecs[i].e_dv));
            if (vecs[i].chk_dout)
                check($sformatf("v%0d_dout", i), 32'(dout), 32'(vecs[i].e_dout));
            check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_count));
            check($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].e_count == 0));
            check($sformatf("v%0d_tz", i), 32'(tos_zero), 32'(vecs[i].e_tz));
            check($sformatf("v%0d_ovf", i), 32'(ovf_err), 32'(vecs[i].e_ovf));
            check($sformatf("v%0d_unf", i), 32'(unf_err), 32'(vecs[i].e_unf));
        end

        // Fill to DEPTH, overflow, clear, then drain checking every spilled entry.
        do_reset(1);
        for (int v = 1; v <= DEPTH; v++) begin
            step(T, F, F, F, 8'(v));
            check($sformatf("fill%0d_count", v), 32'(count), 32'(v));
        end
        check("fill_full", 32'(full), 32'd1);
        step(T, F, F, F, 8'hAA);
        check("ovf_set", 32'(ovf_err), 32'd1);
        check("ovf_count", 32'(count), 32'(DEPTH));
        step(F, F, T, F, 8'h00);
        check("ovf_tos_dv", 32'(dout_valid), 32'd1);
        check("ovf_tos", 32'(dout), 32'(DEPTH));
        step(F, F, F, T, 8'h00);
        check("ovf_clr", 32'(ovf_err), 32'd0);
        step(T, F, F, T, 8'hBB);
        check("ovf_set_beats_clr", 32'(ovf_err), 32'd1);
        step(F, F, F, T, 8'h00);
        // Replace TOS while full is legal.
        step(T, T, F, F, 8'h40);
        check("full_repl_dout", 32'(dout), 32'(DEPTH));
        check("full_repl_count", 32'(count), 32'(DEPTH));
        check("full_repl_ovf", 32'(ovf_err), 32'd0);
        for (int v = DEPTH; v >= 1; v--) begin
            step(F, T, F, F, 8'h00);
            check($sformatf("drain%0d_dv", v), 32'(dout_valid), 32'd1);
            check($sformatf("drain%0d_dout", v), 32'(dout),
                  (v == DEPTH) ? 32'h40 : 32'(v));
            check($sformatf("drain%0d_ready", v), 32'(ready), 32'(v == 1));
            if (v > 1) step(F, F, F, F, 8'h00);
        end
        check("drain_empty", 32'(empty), 32'd1);

        // Reset asserted in the REFILL cycle aborts it.
        for (int v = 1; v <= 6; v++) step(T, F, F, F, 8'(v + 8'h20));
        step(F, T, F, F, 8'h00);
        check("rr_refill", 32'(ready), 32'd0);
        check("rr_count5", 32'(count), 32'd5);
        @(negedge clk);
        rst_n = 1'b0;
        pop   = 1'b0;
        @(posedge clk);
        #1;
        check("rr_ready", 32'(ready), 32'd1);
        check("rr_count", 32'(count), 32'd0);
        check("rr_empty", 32'(empty), 32'd1);
        check("rr_dout", 32'(dout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(T, F, F, F, 8'h3C);
        step(F, F, T, F, 8'h00);
        check("rr_post_dout", 32'(dout), 32'h3C);
        check("rr_post_count", 32'(count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
